// File: rtl/sync_cache.sv
// Direct-mapped cache line store with a four-state request FSM.
// Compare/access reads and writes complete in one LOOKUP cycle; flush invalidates every line in turn.
module sync_cache #(
    parameter int INDEX_W = 4,
    parameter int WORD_W  = 2,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               flush,
    input  logic [INDEX_W-1:0] index,
    input  logic [WORD_W-1:0]  word,
    input  logic               comp,
    input  logic               write,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               valid_in,
    output logic               hit,
    output logic               dirty,
    output logic [TAG_W-1:0]   tag_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               valid,
    output logic               ack,
    output logic               busy
);

    localparam int LINES = 2**INDEX_W;
    localparam int WORDS = 2**WORD_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [INDEX_W-1:0] sweep_q, sweep_d;

    // Request is captured once in IDLE so later input changes cannot disturb it
    logic               req_comp_q, req_write_q, req_valid_q;
    logic [INDEX_W-1:0] req_index_q;
    logic [WORD_W-1:0]  req_word_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [DATA_W-1:0]  req_data_q;

    logic               hit_q, hit_d, dirty_q, dirty_d, valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [LINES-1:0]   vbits_q, dbits_q;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]  data_mem [LINES*WORDS];

    logic               line_valid, line_dirty, lk_hit, load_req, last_sweep;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_word;

    assign line_valid = vbits_q[req_index_q];
    assign line_dirty = dbits_q[req_index_q];
    assign line_tag   = tag_mem[req_index_q];
    assign line_word  = data_mem[{req_index_q, req_word_q}];
    assign lk_hit     = line_valid && (line_tag == req_tag_q);
    assign load_req   = (state_q == S_IDLE) && !flush && enable;
    assign last_sweep = (sweep_q == {INDEX_W{1'b1}});

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        hit_d   = hit_q;
        dirty_d = dirty_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    sweep_d = '0;
                end else if (enable) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_RESP;
                hit_d   = req_comp_q && lk_hit;
                dirty_d = line_dirty;
                valid_d = line_valid;
                tag_d   = line_tag;
                data_d  = line_word;
                if (req_write_q) begin
                    if (!req_comp_q) begin
                        data_d  = req_data_q;
                        tag_d   = req_tag_q;
                        valid_d = req_valid_q;
                        dirty_d = 1'b0;
                    end else if (lk_hit) begin
                        data_d  = req_data_q;
                        dirty_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                sweep_d = sweep_q + INDEX_W'(1);
                if (last_sweep) begin
                    state_d = S_RESP;
                    hit_d   = 1'b0;
                    valid_d = 1'b0;
                    dirty_d = 1'b0;
                end
            end
            default: begin
                if (!enable && !flush) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sweep_q     <= '0;
            hit_q       <= 1'b0;
            dirty_q     <= 1'b0;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            data_q      <= '0;
            req_comp_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_index_q <= '0;
            req_word_q  <= '0;
            req_tag_q   <= '0;
            req_data_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            hit_q   <= hit_d;
            dirty_q <= dirty_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            if (load_req) begin
                req_comp_q  <= comp;
                req_write_q <= write;
                req_valid_q <= valid_in;
                req_index_q <= index;
                req_word_q  <= word;
                req_tag_q   <= tag_in;
                req_data_q  <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vbits_q <= '0;
            dbits_q <= '0;
        end else if (state_q == S_FLUSH) begin
            vbits_q[sweep_q] <= 1'b0;
            dbits_q[sweep_q] <= 1'b0;
        end else if (state_q == S_LOOKUP && req_write_q) begin
            if (!req_comp_q) begin
                vbits_q[req_index_q] <= req_valid_q;
                dbits_q[req_index_q] <= 1'b0;
            end else if (lk_hit) begin
                dbits_q[req_index_q] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; a reset during LOOKUP forces IDLE before the edge, so no write lands
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && req_write_q) begin
            if (!req_comp_q) begin
                tag_mem[req_index_q]               <= req_tag_q;
                data_mem[{req_index_q, req_word_q}] <= req_data_q;
            end else if (lk_hit) begin
                data_mem[{req_index_q, req_word_q}] <= req_data_q;
            end
        end
    end

    assign hit      = hit_q;
    assign dirty    = dirty_q;
    assign valid    = valid_q;
    assign tag_out  = tag_q;
    assign data_out = data_q;
    assign ack      = (state_q == S_RESP);
    assign busy     = (state_q == S_LOOKUP) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_sync_cache.sv
// Directed-vector bench for sync_cache: request timing, all four access modes, flush sweep,
// reset aborts and response holding, with hand-computed expectations.
module tb_sync_cache;

    logic        clk, rst, enable, flush, comp, write, valid_in;
    logic [3:0]  index;
    logic [1:0]  word;
    logic [4:0]  tag_in;
    logic [15:0] data_in;
    logic        hit, dirty, valid, ack, busy;
    logic [4:0]  tag_out;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    sync_cache #(.INDEX_W(4), .WORD_W(2), .TAG_W(5), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .index(index), .word(word), .comp(comp), .write(write),
        .tag_in(tag_in), .data_in(data_in), .valid_in(valid_in),
        .hit(hit), .dirty(dirty), .tag_out(tag_out), .data_out(data_out),
        .valid(valid), .ack(ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic [3:0] i, input logic [1:0] wd,
                         input logic [4:0] t, input logic [15:0] d, input logic v);
        comp = c; write = w; index = i; word = wd; tag_in = t; data_in = d; valid_in = v;
    endtask

    // Full handshake: enable held until ack, then dropped; ack must fall one cycle later
    task automatic req(input logic c, input logic w, input logic [3:0] i, input logic [1:0] wd,
                       input logic [4:0] t, input logic [15:0] d, input logic v);
        @(posedge clk); #1;
        drive(c, w, i, wd, t, d, v);
        enable = 1'b1;
        @(posedge clk); #1;
        check("lookup_busy", busy, 1);
        check("lookup_ack", ack, 0);
        @(posedge clk); #1;
        check("resp_ack", ack, 1);
        check("resp_busy", busy, 0);
        enable = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("idle_ack", ack, 0);
    endtask

    task automatic outs(input string name, input logic h, input logic v, input logic dt,
                        input logic [4:0] t, input logic [15:0] d);
        check({name, "_hit"},   hit, h);
        check({name, "_valid"}, valid, v);
        check({name, "_dirty"}, dirty, dt);
        check({name, "_tag"},   tag_out, t);
        check({name, "_data"},  data_out, d);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        outs("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // cold compare-read misses
        req(1, 0, 3, 0, 5, 0, 0);
        check("cold_hit", hit, 0);
        check("cold_valid", valid, 0);
        check("cold_dirty", dirty, 0);

        req(0, 1, 3, 1, 5, 16'hBEEF, 1);
        outs("awr", 0, 1, 0, 5, 16'hBEEF);
        req(1, 0, 3, 1, 5, 0, 0);
        outs("crd_hit", 1, 1, 0, 5, 16'hBEEF);

        req(1, 1, 3, 2, 5, 16'h1234, 0);
        outs("cwr_hit", 1, 1, 1, 5, 16'h1234);
        req(1, 0, 3, 2, 6, 0, 0);
        outs("crd_miss", 0, 1, 1, 5, 16'h1234);

        // compare-write miss must leave the word untouched
        req(1, 1, 3, 2, 6, 16'h5555, 0);
        outs("cwr_miss", 0, 1, 1, 5, 16'h1234);
        req(0, 0, 3, 2, 0, 0, 0);
        outs("ard", 0, 1, 1, 5, 16'h1234);
        req(0, 0, 3, 1, 0, 0, 0);
        check("ard_w1", data_out, 16'hBEEF);

        // enable held in RESP with changing inputs: no second operation
        @(posedge clk); #1;
        drive(0, 0, 3, 2, 0, 0, 0);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hold_ack0", ack, 1);
        drive(1, 1, 3, 2, 5, 16'hFFFF, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_ack", ack, 1);
            check("hold_busy", busy, 0);
            check("hold_data", data_out, 16'h1234);
        end
        enable = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("hold_release", ack, 0);
        req(0, 0, 3, 2, 0, 0, 0);
        check("hold_nowrite", data_out, 16'h1234);

        // enable dropped during LOOKUP still completes with a one-cycle ack
        @(posedge clk); #1;
        drive(0, 1, 4, 0, 7, 16'hCAFE, 1);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("drop_busy", busy, 1);
        @(posedge clk); #1;
        check("drop_ack", ack, 1);
        outs("drop", 0, 1, 0, 7, 16'hCAFE);
        @(posedge clk); #1;
        check("drop_ack_low", ack, 0);

        // flush wins over enable; 16 busy cycles then ack
        @(posedge clk); #1;
        flush = 1'b1; enable = 1'b1;
        drive(1, 1, 3, 1, 5, 16'h0BAD, 1);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            check("flush_busy", busy, 1);
            check("flush_ack", ack, 0);
        end
        @(posedge clk); #1;
        check("flush_done_ack", ack, 1);
        check("flush_done_busy", busy, 0);
        check("flush_done_hit", hit, 0);
        check("flush_done_valid", valid, 0);
        check("flush_done_dirty", dirty, 0);
        flush = 1'b0; enable = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("flush_idle", ack, 0);
        req(1, 0, 3, 1, 5, 0, 0);
        outs("post_flush", 0, 0, 0, 5, 16'hBEEF);
        req(1, 0, 4, 0, 7, 0, 0);
        check("post_flush4_valid", valid, 0);

        // reset at sweep line 7 aborts; line 10 beyond the sweep is still cleared
        req(0, 1, 10, 0, 3, 16'h7777, 1);
        req(0, 1, 3, 0, 2, 16'h3333, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_flush_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_flush_ack", ack, 0);
        check("rst_flush_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req(0, 0, 10, 0, 0, 0, 0);
        outs("rst_l10", 0, 0, 0, 3, 16'h7777);
        req(0, 0, 3, 0, 0, 0, 0);
        check("rst_l3_valid", valid, 0);

        // reset during LOOKUP: the pending access-write must not land
        req(0, 1, 5, 0, 4, 16'h1111, 1);
        @(posedge clk); #1;
        drive(0, 1, 5, 0, 9, 16'hAAAA, 1);
        enable = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 1);
        rst = 1'b1;
        enable = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("abort_busy_rst", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req(0, 0, 5, 0, 0, 0, 0);
        outs("abort", 0, 0, 0, 4, 16'h1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_cache.md
SYNC_CACHE -- requirements
Module: sync_cache

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning line-index width; line count 2**INDEX_W.
REQ-002 SHALL have parameter WORD_W, default 2, meaning word-offset width; words per line 2**WORD_W.
REQ-003 SHALL have parameter TAG_W, default 5, meaning tag width.
REQ-004 SHALL have parameter DATA_W, default 16, meaning word data width.
REQ-005 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  enable  in  1  request; held high until ack seen
  flush  in  1  request invalidate-all sweep
  index  in  INDEX_W  line select
  word  in  WORD_W  word select within line
  comp  in  1  1 = compare mode, 0 = access mode
  write  in  1  1 = write, 0 = read
  tag_in  in  TAG_W  tag for compare/fill
  data_in  in  DATA_W  write data
  valid_in  in  1  valid bit for access-write
  hit  out  1  tag match on valid line (compare modes)
  dirty  out  1  dirty bit of addressed line
  tag_out  out  TAG_W  stored tag of addressed line
  data_out  out  DATA_W  stored word
  valid  out  1  valid bit of addressed line
  ack  out  1  operation complete
  busy  out  1  FSM in LOOKUP or FLUSH
REQ-006 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-007 SHALL implement FSM states IDLE, LOOKUP, FLUSH, RESP.
REQ-008 IDLE: flush=1 -> FLUSH, sweep counter=0; else enable=1 -> register all request inputs, -> LOOKUP; flush has priority over enable in the same cycle.
REQ-009 LOOKUP (one cycle): perform operation on registered request, register outputs, -> RESP.
REQ-010 Compare-read (comp=1, write=0): hit=valid&(tag==tag_in); data_out, tag_out, valid, dirty from line; no state change.
REQ-011 Compare-write (comp=1, write=1): on hit write data_in to word, set line dirty=1, hit=1; on miss no write, hit=0; outputs reflect line after operation.
REQ-012 Access-read (comp=0, write=0): hit=0; data_out, tag_out, valid, dirty from line.
REQ-013 Access-write (comp=0, write=1): write data_in to word, tag=tag_in, valid=valid_in, dirty=0; hit=0; outputs reflect written line.
REQ-014 FLUSH: clear valid and dirty of line sweep counter per cycle, counter+1; after line 2**INDEX_W-1 -> RESP; latency exactly 2**INDEX_W cycles; hit=0, valid=0, dirty=0 on completion.
REQ-015 RESP: ack=1; hold outputs; stay until enable=0 and flush=0, then -> IDLE with ack=0 next cycle.
REQ-016 Request latency: enable sampled at edge N -> ack high after edge N+2.
REQ-017 Inputs changing during LOOKUP/FLUSH/RESP SHALL be ignored; a new request requires return to IDLE.
REQ-018 enable dropped during LOOKUP SHALL still complete the operation; ack high one cycle, then IDLE.
REQ-019 busy SHALL be 1 exactly in LOOKUP and FLUSH.
REQ-020 Outputs SHALL change only on LOOKUP completion or FLUSH completion; stable otherwise.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, ack=0, busy=0, hit=0, dirty=0, valid=0, tag_out=0, data_out=0, sweep counter=0.
REQ-022 rst SHALL clear all valid and dirty bits; tag and data storage not reset.
REQ-023 rst asserted mid-LOOKUP or mid-FLUSH SHALL abort; no partial write completed after reset release.

Verification
REQ-024 rst, then compare-read index=3 tag=5 -> ack after 2 cycles, hit=0, valid=0, dirty=0.
REQ-025 access-write index=3 word=1 tag=5 data=16'hBEEF valid_in=1, then compare-read same -> hit=1, data_out=16'hBEEF, dirty=0, valid=1.
REQ-026 compare-write index=3 word=2 tag=5 data=16'h1234 -> hit=1; then compare-read word=2 tag=6 -> hit=0, tag_out=5, dirty=1, data_out=16'h1234.
REQ-027 flush and enable raised same cycle -> FLUSH taken, ack after 16 cycles, busy high 16 cycles; then compare-read index=3 tag=5 -> hit=0, valid=0, dirty=0.
REQ-028 rst pulsed during FLUSH at line 7 -> ack=0, busy=0 immediately; all valid bits read 0 afterwards.
REQ-029 enable held high in RESP for 5 cycles -> ack stays 1, outputs unchanged, no second operation.
